// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller between issue and an SRAM-like data bus
module mem_access_ctrl #(
  parameter int PREG_W = 6,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              mem_issued,
  input  logic              op_store,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  input  logic [PREG_W-1:0] op_preg,
  output logic              wait_mem,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              commit_valid,
  output logic              commit_store,
  output logic [PREG_W-1:0] commit_preg,
  output logic [31:0]       commit_data
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t state, state_nx;
  logic              c_store, c_unsigned, complete;
  logic [1:0]        c_size;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata, sh, ld_data;
  logic [PREG_W-1:0] c_preg;
  always_comb begin
    state_nx = state;
    complete = 1'b0;
    case (state)
      IDLE: state_nx = (mem_issued && !flush) ? REQ : IDLE;
      REQ: begin
        complete = data_addr_ok && data_data_ok && !flush;
        state_nx = !data_addr_ok ? (flush ? IDLE : REQ) : data_data_ok ? IDLE : flush ? DRAIN : WAIT;
      end
      WAIT: begin
        complete = data_data_ok && !flush;
        state_nx = data_data_ok ? IDLE : flush ? DRAIN : WAIT;
      end
      default: state_nx = data_data_ok ? IDLE : DRAIN;
    endcase
  end
  assign wait_mem   = state != IDLE;
  assign data_req   = state == REQ;
  assign data_wr    = c_store;
  assign data_size  = c_size;
  assign data_addr  = c_addr;
  assign data_wdata = c_size == 2'd0 ? {4{c_wdata[7:0]}} : c_size == 2'd1 ? {2{c_wdata[15:0]}} : c_wdata;
  // Byte/half lanes are selected by shifting the addressed lane down to bit 0
  assign sh      = data_rdata >> {c_addr[1:0], 3'b000};
  assign ld_data = c_size == 2'd0 ? {{24{!c_unsigned && sh[7]}}, sh[7:0]} :
                   c_size == 2'd1 ? {{16{!c_unsigned && sh[15]}}, sh[15:0]} : data_rdata;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      c_store      <= 1'b0;
      c_unsigned   <= 1'b0;
      c_size       <= '0;
      c_addr       <= '0;
      c_wdata      <= '0;
      c_preg       <= '0;
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      commit_preg  <= '0;
      commit_data  <= '0;
    end else begin
      state        <= state_nx;
      commit_valid <= complete;
      if (state == IDLE && mem_issued && !flush) begin
        c_store    <= op_store;
        c_unsigned <= op_unsigned;
        c_size     <= op_size;
        c_addr     <= op_addr;
        c_wdata    <= op_wdata;
        c_preg     <= op_preg;
      end
      if (complete) begin
        commit_store <= c_store;
        commit_preg  <= c_preg;
        commit_data  <= c_store ? 32'd0 : ld_data;
      end
    end
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Single-outstanding memory-access controller, directly downstream of the issue stage's memory port.
- Accepts one load/store per handshake from issue (mem_issued) and stalls further memory issue (wait_mem) while busy.
- Drives the SRAM-like data bus (req / addr_ok / data_ok) and returns aligned, extended load data plus destination preg to commit.
- Discards in-flight results on pipeline flush without violating the bus protocol.

Parameters:
- PREG_W, 6, width of physical-register (ROB) tag.
- ADDR_W, 32, data-bus address width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush (branch mispredict / exception); kills current op.
- mem_issued  in  1  issue hands over one memory op this cycle.
- op_store  in  1  1 = store, 0 = load.
- op_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- op_unsigned  in  1  zero-extend load (LBU/LHU).
- op_addr  in  ADDR_W  physical address, already alignment-checked upstream.
- op_wdata  in  32  store data, right-aligned.
- op_preg  in  PREG_W  destination/ROB tag.
- wait_mem  out  1  controller busy; issue must not assert mem_issued.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  bus size.
- data_addr  out  ADDR_W  bus address.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response / write-complete.
- data_rdata  in  32  raw read word.
- commit_valid  out  1  one-cycle result pulse to commit.
- commit_store  out  1  completed op was a store.
- commit_preg  out  PREG_W  tag of completed op.
- commit_data  out  32  extended load data (0 for stores).

Behaviour:
- Reset (resetn low, async): state IDLE; every output 0; captured op registers 0.
- FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE: on mem_issued (and no flush in the same cycle), capture all op fields and go to REQ. mem_issued in any other state is ignored.
  - REQ: data_req = 1; bus fields are driven from the captured registers and held stable until addr_ok.
    - addr_ok & !flush → WAIT. addr_ok & data_ok in the same cycle → completes (see WAIT).
    - flush & !addr_ok → IDLE; request withdrawn, no commit.
    - flush & addr_ok → DRAIN. If data_ok is also high that cycle → IDLE, no commit.
  - WAIT: data_req = 0.
    - data_ok & !flush → IDLE; commit_valid = 1 in the next cycle (registered).
    - flush & !data_ok → DRAIN.
    - flush & data_ok → IDLE, no commit.
  - DRAIN: wait for data_ok, then → IDLE; result discarded. flush is ignored in this state.
- wait_mem = (state != IDLE), registered-state based. The cycle after a completion, wait_mem = 0, so a new mem_issued may coincide with commit_valid.
- Latency: mem_issued at cycle N → data_req at N+1. With addr_ok = data_ok = 1 at N+1, commit_valid is at N+2. Minimum occupancy is 2 cycles per op.
- commit_valid is a one-cycle pulse. commit_* fields hold their last value while commit_valid = 0. There is no backpressure from commit.
- Store data lane replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- data_addr = captured op_addr unmodified. data_size = op_size.
- Load extraction: shift data_rdata right by 8 × addr[1:0], then take the low byte or half and sign- or zero-extend per op_unsigned. Word loads use rdata unchanged.
- A flush in the same cycle as mem_issued in IDLE: the op is not captured.
- Reset asserted mid-transaction returns to IDLE immediately; bus-side recovery is the bus owner's responsibility.

Test Plan:
- Word load, addr 0x1000, preg 5, bus addr_ok = data_ok = 1 on the first req cycle, rdata 0xDEADBEEF → data_req for exactly 1 cycle; commit_valid at N+2 with data 0xDEADBEEF, preg 5; wait_mem high only at N+1.
- Signed byte load, addr 0x1003, rdata 0x80FF0011 → commit_data 0xFFFFFF80. Same load with op_unsigned = 1 → 0x00000080. Half load at 0x1002 signed, rdata 0x8001xxxx → 0xFFFF8001.
- Byte store, addr 0x2001, wdata 0x000000AB, addr_ok delayed 3 cycles, data_ok 2 cycles later → data_req held 4 cycles with stable fields, data_wr = 1, wdata 0xABABABAB; commit_valid with commit_store = 1 and data 0.
- Flush while in REQ before addr_ok → data_req drops the next cycle, state IDLE, no commit_valid, wait_mem low.
- Flush in WAIT, data_ok 4 cycles later → wait_mem stays high through DRAIN until data_ok; no commit_valid. A mem_issued during DRAIN is ignored.
- Back-to-back: second mem_issued in the same cycle as the first op's commit_valid → accepted; second data_req on the next cycle.
